// File: rtl/pc_hazard_ctrl.sv
// PC / hazard control for the pipelined datapath: load-use stalls, EX-stage redirects, reset and halt sequencing.
// Optional target alignment checking is enabled by defining PC_ALIGN_CHECK_EN.
module pc_hazard_ctrl #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       ID_Rs1,
  input  logic [4:0]       ID_Rs2,
  input  logic             ID_UsesRs1,
  input  logic             ID_UsesRs2,
  input  logic             ID_IsHalt,
  input  logic [4:0]       EX_Rd,
  input  logic             EX_MemRead,
  input  logic             EX_BranchTaken,
  input  logic [XLEN-1:0]  EX_BranchTarget,
  output logic             PCWrite,
  output logic             Jump,
  output logic [XLEN-1:0]  NewPC,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             Halted,
  output logic             Fault,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             fault_q;
  logic             load_use;
  logic             misalign;
  logic             stall_evt;
  logic             flush_evt;
  logic             fault_evt;

  // Load in EX feeding a register the ID instruction actually reads; x0 is never a real dependency.
  assign load_use = EX_MemRead && (EX_Rd != 5'd0) &&
                    ((ID_UsesRs1 && (ID_Rs1 == EX_Rd)) ||
                     (ID_UsesRs2 && (ID_Rs2 == EX_Rd)));

`ifdef PC_ALIGN_CHECK_EN
  assign misalign = (EX_BranchTarget[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Next state and combinational pipeline control.
  always_comb begin
    state_next = state;
    PCWrite    = 1'b0;
    Jump       = 1'b0;
    NewPC      = RESET_PC;
    IFIDWrite  = 1'b0;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    Halted     = 1'b0;
    stall_evt  = 1'b0;
    flush_evt  = 1'b0;
    fault_evt  = 1'b0;

    if (Reset) begin
      IFIDFlush  = 1'b1;
      IDEXFlush  = 1'b1;
      state_next = ST_INIT;
    end else begin
      unique case (state)
        ST_INIT: begin
          PCWrite    = 1'b1;
          Jump       = 1'b1;
          IFIDFlush  = 1'b1;
          IDEXFlush  = 1'b1;
          state_next = ST_RUN;
        end

        ST_RUN: begin
          if (EX_BranchTaken) begin
            // The ID instruction is squashed, so its halt or hazard does not matter.
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
            if (misalign) begin
              fault_evt  = 1'b1;
              state_next = ST_HALT;
            end else begin
              PCWrite   = 1'b1;
              Jump      = 1'b1;
              NewPC     = EX_BranchTarget;
              IFIDWrite = 1'b1;
              flush_evt = 1'b1;
            end
          end else if (ID_IsHalt) begin
            state_next = ST_HALT;
          end else if (load_use) begin
            IDEXFlush = 1'b1;
            stall_evt = 1'b1;
          end else begin
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
          end
        end

        ST_HALT: begin
          IDEXFlush = 1'b1;
          Halted    = 1'b1;
        end

        default: begin
          state_next = ST_INIT;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_evt && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fault_q <= 1'b0;
    end else if (fault_evt) begin
      fault_q <= 1'b1;
    end
  end

  assign Fault      = fault_q;
  assign StallCount = stall_cnt;
  assign FlushCount = flush_cnt;

endmodule

// File: doc/pc_hazard_ctrl.md
Name: pc_hazard_ctrl

Overview:
- Generates the PC-control inputs of the pipelined Datapath: `PCWrite`, `Jump` and `NewPC`, plus IF/ID write enable and stage flushes.
- Detects load-use hazards between the ID and EX stages, redirects fetch on branches resolved in EX, and sequences reset and halt.
- Sits beside Datapath in the CPU top and drives the signals that benches currently drive by hand.

Parameters:
- XLEN, 64, width of PC and branch target.
- RESET_PC, 64'h0, fetch address forced by the reset sequence.
- CNT_W, 32, width of the stall and flush performance counters.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- ID_Rs1  input  5  rs1 field of the instruction in the IF/ID register.
- ID_Rs2  input  5  rs2 field of the instruction in the IF/ID register.
- ID_UsesRs1  input  1  ID instruction reads rs1.
- ID_UsesRs2  input  1  ID instruction reads rs2.
- ID_IsHalt  input  1  ID instruction is ebreak/halt.
- EX_Rd  input  5  destination register of the instruction in EX.
- EX_MemRead  input  1  instruction in EX is a load.
- EX_BranchTaken  input  1  branch/jump in EX resolved taken.
- EX_BranchTarget  input  XLEN  resolved target address.
- PCWrite  output  1  PC register load enable.
- Jump  output  1  select NewPC instead of PC+4.
- NewPC  output  XLEN  redirect address.
- IFIDWrite  output  1  IF/ID register load enable.
- IFIDFlush  output  1  clear IF/ID to a NOP.
- IDEXFlush  output  1  insert a bubble into ID/EX.
- Halted  output  1  FSM is in HALT.
- Fault  output  1  sticky fault flag (optional feature only; otherwise 0).
- StallCount  output  CNT_W  number of load-use stall cycles.
- FlushCount  output  CNT_W  number of taken redirects.

Behaviour:
- Single clock Clk. Reset is synchronous and active-high.
- FSM states: INIT, RUN, HALT. State and counters are registered. Control outputs are combinational from state and inputs.
- Reset=1, sampled at an edge:
  - Next state INIT; StallCount=0, FlushCount=0, Fault=0.
  - Outputs while Reset=1: PCWrite=0, Jump=0, NewPC=RESET_PC, IFIDWrite=0, IFIDFlush=1, IDEXFlush=1, Halted=0.
  - Reset asserted mid-operation (any state, including mid-stall) takes effect at the next edge.
- INIT, one cycle:
  - PCWrite=1, Jump=1, NewPC=RESET_PC, IFIDWrite=0, IFIDFlush=1, IDEXFlush=1.
  - Next state RUN.
- RUN, priority highest first:
  1. EX_BranchTaken=1:
     - Jump=1, NewPC=EX_BranchTarget, PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXFlush=1.
     - FlushCount++.
     - Any halt or hazard seen in ID this cycle is ignored, because that instruction is squashed.
  2. ID_IsHalt=1:
     - PCWrite=0, IFIDWrite=0, no flush; the halt proceeds to EX.
     - Next state HALT.
  3. Load-use hazard: EX_MemRead=1, EX_Rd≠0, and (ID_UsesRs1 and ID_Rs1==EX_Rd, or ID_UsesRs2 and ID_Rs2==EX_Rd):
     - PCWrite=0, IFIDWrite=0, IDEXFlush=1, Jump=0.
     - StallCount++.
     - Stall lasts exactly 1 cycle: next cycle EX holds the bubble, so EX_MemRead=0.
  4. Otherwise: PCWrite=1, IFIDWrite=1, Jump=0, no flush, NewPC=RESET_PC (don't-care).
- HALT:
  - PCWrite=0, IFIDWrite=0, IDEXFlush=1, Jump=0, Halted=1.
  - Exits only via Reset. EX_BranchTaken is ignored in HALT.
- Counters saturate at all-ones and do not wrap.
- A stall and a branch in the same cycle count only as a flush.
- EX_Rd=0 never stalls.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - In RUN, EX_BranchTaken=1 with EX_BranchTarget[1:0]≠0 is a fault, not a redirect.
  - Outputs that cycle: PCWrite=0, IFIDFlush=1, IDEXFlush=1, Jump=0.
  - Fault is set (sticky until Reset); next state HALT.
  - FlushCount is not incremented.
- Not defined: targets are used unchecked and Fault is constant 0.

Test Plan:
- Reset=1 for 2 cycles, then 0 -> while Reset=1: PCWrite=0, IFIDFlush=1; first cycle after release (INIT): Jump=1, NewPC=0, PCWrite=1; next cycle RUN: PCWrite=1, Jump=0.
- EX_MemRead=1, EX_Rd=15, ID_Rs1=15, ID_UsesRs1=1, then EX_MemRead=0 next cycle -> one cycle of PCWrite=0, IFIDWrite=0, IDEXFlush=1; StallCount=1; PCWrite=1 the cycle after.
- Same as previous but EX_Rd=0, ID_Rs1=0 -> no stall; StallCount stays 0.
- EX_BranchTaken=1, EX_BranchTarget=64'h28, with a simultaneous load-use hazard in ID -> Jump=1, NewPC=28h, IFIDFlush=1, IDEXFlush=1; FlushCount=1; StallCount unchanged.
- ID_IsHalt=1 -> that cycle PCWrite=0; next cycles Halted=1, IDEXFlush=1; EX_BranchTaken=1 while halted has no effect; Reset=1 returns FSM to INIT and clears both counters.
- With PC_ALIGN_CHECK_EN defined: EX_BranchTaken=1, target 64'h22 -> Fault=1, Halted=1 next cycle, Jump=0, FlushCount unchanged. Without the macro: Jump=1, NewPC=22h.
